// File: rtl/add4_share_arbiter_if.sv
// Request/response bundle for the shared adder arbiter.
// rsp_carry exists only when ADD4_CARRY_EN is defined.
interface add4_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_sum;
    logic [ID_W-1:0]        rsp_id;
`ifdef ADD4_CARRY_EN
    logic                   rsp_carry;
`endif

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id
`ifdef ADD4_CARRY_EN
        , input rsp_carry
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
`ifdef ADD4_CARRY_EN
        , output rsp_carry
`endif
    );
endinterface

// File: rtl/add4_share_arbiter.sv
// Round-robin arbiter sharing one modulo-2^WIDTH adder among N_REQ clients.
// Optional ADD4_CARRY_EN adds a registered rsp_carry output.
module add4_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add4_share_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_ptr;

    logic             w_can;
    logic             w_found;
    logic             w_acc;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_nxt;
    logic [N_REQ-1:0] w_grant;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_can = (r_state == IDLE) | bus.rsp_ready;

    // Two passes: from r_ptr upward, then wrap from 0 below r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_found && j >= int'(r_ptr) && bus.req_valid[j]) begin
                w_found = 1'b1;
                w_idx   = ID_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_found && j < int'(r_ptr) && bus.req_valid[j]) begin
                w_found = 1'b1;
                w_idx   = ID_W'(j);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        w_a     = '0;
        w_b     = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_found && w_idx == ID_W'(j)) begin
                w_grant[j] = 1'b1;
                w_a        = bus.req_a[j*WIDTH +: WIDTH];
                w_b        = bus.req_b[j*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.req_ready = w_grant & {N_REQ{w_can & rst_n}};
    assign w_acc = w_found & w_can;
    assign w_nxt = (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;

`ifdef ADD4_CARRY_EN
    logic             r_carry;
    logic [WIDTH:0]   w_add;
    assign w_add = {1'b0, w_a} + {1'b0, w_b};
    assign bus.rsp_carry = r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (w_acc) begin
            r_carry <= w_add[WIDTH];
        end
    end
`else
    logic [WIDTH-1:0] w_add;
    assign w_add = w_a + w_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_acc) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
            r_sum   <= w_add[WIDTH-1:0];
            r_id    <= w_idx;
            r_ptr   <= w_nxt;
        end else if (r_state == HOLD && bus.rsp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = r_valid;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_id    = r_id;
endmodule
